streaming_core_dispatcher: RTL and testbench
============================================

STREAMING_CORE_DISPATCHER -- requirements
Module: streaming_core_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4: number of attached streaming count-connected cores, 2..8.
REQ-002 The block SHALL have parameter EXTRA_DATA_WIDTH, default 1: width of the per-bot sideband tag.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 10: width of each per-core outstanding counter; 512-entry core ring plus margin.
REQ-004 The block SHALL have the following ports:
- clk  in  1: single clock; all logic is rising-edge.
- rstn  in  1: asynchronous, active-low reset.
- inValid  in  1: upstream bot valid.
- graphIn  in  128: upstream graph.
- extraDataIn  in  EXTRA_DATA_WIDTH: upstream sideband.
- inReady  out  1: upstream may transfer this cycle.
- coreEnable  in  NUM_CORES: per-core dispatch enable mask.
- coreSlowDown  in  NUM_CORES: per-core input-FIFO almost-full.
- coreBotValid  out  NUM_CORES: one-hot per-core input strobe.
- coreGraph  out  128: shared graph bus to all cores.
- coreExtraData  out  EXTRA_DATA_WIDTH: shared sideband bus.
- coreResultValid  in  NUM_CORES: per-core result strobe.
- coreConnectCount  in  6*NUM_CORES: per-core counts; core i occupies bits [6i+5:6i].
- coreExtraDataOut  in  EXTRA_DATA_WIDTH*NUM_CORES: per-core returned sideband.
- coreEcc  in  NUM_CORES: per-core ECC status.
- resultValid  out  1: merged result strobe.
- connectCount  out  6: merged count.
- extraDataOut  out  EXTRA_DATA_WIDTH: merged sideband.
- idle  out  1: no bots outstanding anywhere.
- eccStatus  out  1: sticky ECC flag.
- collisionError  out  1: sticky flag for simultaneous results.
- counterError  out  1: sticky flag for counter over/underflow.

Function
REQ-005 Core i SHALL be eligible when coreEnable[i]=1 and coreSlowDown[i]=0; inReady SHALL be combinational OR of eligibility.
REQ-006 A transfer occurs when inValid and inReady are both 1 in the same cycle; inValid without inReady SHALL have no effect.
REQ-007 The selected core SHALL be the first eligible index at or after rrPtr, searching upward with wrap at NUM_CORES.
REQ-008 On transfer, rrPtr SHALL become (selected+1) mod NUM_CORES; without a transfer, rrPtr SHALL hold.
REQ-009 Dispatch outputs SHALL be registered: one cycle after a transfer, coreBotValid SHALL be one-hot on the selected core and coreGraph/coreExtraData SHALL carry the transferred data; otherwise coreBotValid SHALL be 0 and the buses SHALL hold their last value.
REQ-010 At most one transfer SHALL occur per cycle.
REQ-011 Result merge SHALL have 1-cycle registered latency: resultValid(t+1)=OR(coreResultValid(t)).
REQ-012 connectCount and extraDataOut SHALL come from the lowest-index valid core; when none is valid they SHALL hold their last value.
REQ-013 If more than one coreResultValid bit is 1 in a cycle, collisionError SHALL set and remain set until reset.
REQ-014 Each core SHALL have an outstanding counter:
- +1 on dispatch to that core, counted in the registered coreBotValid cycle;
- -1 on coreResultValid[i];
- simultaneous +1 and -1 on the same core: unchanged.
REQ-015 A decrement at 0 or an increment at all-ones SHALL leave the counter unchanged and set counterError (sticky).
REQ-016 idle SHALL be 1 when all counters are 0, coreBotValid is 0, and no transfer occurs in the current cycle.
REQ-017 eccStatus SHALL register the OR of coreEcc and, once set, remain set until reset.
REQ-018 Clearing coreEnable or asserting coreSlowDown SHALL affect selection in the same cycle; in-flight bots of a disabled core SHALL still be merged and counted.

Reset
REQ-019 While rstn=0, the block SHALL hold:
- rrPtr=0; all counters 0;
- coreBotValid=0; resultValid=0; coreGraph=0; coreExtraData=0; connectCount=0; extraDataOut=0;
- eccStatus=0; collisionError=0; counterError=0; idle=1.
REQ-020 Reset assertion mid-operation SHALL discard in-flight bookkeeping immediately; after release, dispatch SHALL resume at core 0.

Verification
REQ-021 All cores enabled, inValid held high for 8 cycles -> coreBotValid sequence 0001,0010,0100,1000,0001,... beginning one cycle after the first transfer; counters 2,2,2,2.
REQ-022 coreSlowDown=0010 with rrPtr=1 -> core 2 selected, rrPtr=3; coreSlowDown=1111 -> inReady=0, no strobe, rrPtr held.
REQ-023 coreResultValid=0100, count 6'd17, extra 1 -> next cycle resultValid=1, connectCount=17, extraDataOut=1, core-2 counter decrements by 1.
REQ-024 coreResultValid=0110 -> core-1 data output, collisionError=1 persisting across later clean cycles.
REQ-025 Result on a core with counter 0 -> counterError=1 and counter stays 0; coreEcc[3] pulse -> eccStatus=1 sticky.
REQ-026 rstn pulsed low with counters nonzero -> all outputs at REQ-019 values immediately; next transfer goes to core 0.

Source files
------------

// File: rtl/streaming_core_dispatcher.sv
// Round-robin bot dispatcher for NUM_CORES streaming cores: registered dispatch,
// registered result merge, per-core outstanding counters and sticky error flags.

module sc_core_counter #(
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 err
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc && !dec) begin
      if (&cnt_q) err = 1'b1;
      else        cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

module streaming_core_dispatcher #(
  parameter int NUM_CORES        = 4,
  parameter int EXTRA_DATA_WIDTH = 1,
  parameter int CNT_WIDTH        = 10
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  inValid,
  input  logic [127:0]                          graphIn,
  input  logic [EXTRA_DATA_WIDTH-1:0]           extraDataIn,
  output logic                                  inReady,
  input  logic [NUM_CORES-1:0]                  coreEnable,
  input  logic [NUM_CORES-1:0]                  coreSlowDown,
  output logic [NUM_CORES-1:0]                  coreBotValid,
  output logic [127:0]                          coreGraph,
  output logic [EXTRA_DATA_WIDTH-1:0]           coreExtraData,
  input  logic [NUM_CORES-1:0]                  coreResultValid,
  input  logic [6*NUM_CORES-1:0]                coreConnectCount,
  input  logic [EXTRA_DATA_WIDTH*NUM_CORES-1:0] coreExtraDataOut,
  input  logic [NUM_CORES-1:0]                  coreEcc,
  output logic                                  resultValid,
  output logic [5:0]                            connectCount,
  output logic [EXTRA_DATA_WIDTH-1:0]           extraDataOut,
  output logic                                  idle,
  output logic                                  eccStatus,
  output logic                                  collisionError,
  output logic                                  counterError
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef struct packed {
    logic [127:0]                graph;
    logic [EXTRA_DATA_WIDTH-1:0] extra;
  } disp_t;

  typedef struct packed {
    logic [5:0]                  count;
    logic [EXTRA_DATA_WIDTH-1:0] extra;
  } rsp_t;

  logic [NUM_CORES-1:0]                eligible;
  logic [PTR_W-1:0]                    sel;
  logic                                xfer;
  logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0]                bot_valid_q, bot_valid_d;
  disp_t                               disp_q, disp_d;
  logic                                res_valid_q, res_valid_d;
  rsp_t                                rsp_q, rsp_d;
  logic                                ecc_q, ecc_d;
  logic                                col_q, col_d;
  logic                                cerr_q, cerr_d;
  logic [NUM_CORES-1:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_CORES-1:0]                cnt_err;

  assign eligible = coreEnable & ~coreSlowDown;
  assign inReady  = |eligible;
  assign xfer     = inValid & inReady;

  // First eligible core at or after rr_ptr, wrapping at NUM_CORES.
  always_comb begin : sel_search
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    bot_valid_d = '0;
    disp_d      = disp_q;
    if (xfer) begin
      rr_ptr_d         = (int'(sel) == NUM_CORES - 1) ? '0 : sel + PTR_W'(1);
      bot_valid_d[sel] = 1'b1;
      disp_d.graph     = graphIn;
      disp_d.extra     = extraDataIn;
    end
  end

  // Walk from the top down so the lowest-index valid core wins the merge.
  always_comb begin
    res_valid_d = |coreResultValid;
    rsp_d       = rsp_q;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (coreResultValid[i]) begin
        rsp_d.count = coreConnectCount[6*i +: 6];
        rsp_d.extra = coreExtraDataOut[EXTRA_DATA_WIDTH*i +: EXTRA_DATA_WIDTH];
      end
    end
    ecc_d  = ecc_q | (|coreEcc);
    col_d  = col_q | (|(coreResultValid & (coreResultValid - NUM_CORES'(1))));
    cerr_d = cerr_q | (|cnt_err);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q    <= '0;
      bot_valid_q <= '0;
      disp_q      <= '0;
      res_valid_q <= 1'b0;
      rsp_q       <= '0;
      ecc_q       <= 1'b0;
      col_q       <= 1'b0;
      cerr_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      bot_valid_q <= bot_valid_d;
      disp_q      <= disp_d;
      res_valid_q <= res_valid_d;
      rsp_q       <= rsp_d;
      ecc_q       <= ecc_d;
      col_q       <= col_d;
      cerr_q      <= cerr_d;
    end
  end

  // Counters see the registered strobe so a bot counts once it leaves the dispatcher.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    sc_core_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (bot_valid_q[g]),
      .dec  (coreResultValid[g]),
      .cnt  (cnt[g]),
      .err  (cnt_err[g])
    );
  end

  assign coreBotValid   = bot_valid_q;
  assign coreGraph      = disp_q.graph;
  assign coreExtraData  = disp_q.extra;
  assign resultValid    = res_valid_q;
  assign connectCount   = rsp_q.count;
  assign extraDataOut   = rsp_q.extra;
  assign eccStatus      = ecc_q;
  assign collisionError = col_q;
  assign counterError   = cerr_q;
  assign idle           = rstn ? ((cnt == '0) && (bot_valid_q == '0) && !xfer) : 1'b1;
endmodule

// File: tb/tb_streaming_core_dispatcher.sv
// Directed vector bench for streaming_core_dispatcher (4 cores, 1-bit sideband).

module tb_streaming_core_dispatcher;
  logic         clk = 1'b0;
  logic         rstn;
  logic         inValid;
  logic [127:0] graphIn;
  logic [0:0]   extraDataIn;
  logic         inReady;
  logic [3:0]   coreEnable, coreSlowDown, coreBotValid;
  logic [127:0] coreGraph;
  logic [0:0]   coreExtraData;
  logic [3:0]   coreResultValid;
  logic [23:0]  coreConnectCount;
  logic [3:0]   coreExtraDataOut;
  logic [3:0]   coreEcc;
  logic         resultValid;
  logic [5:0]   connectCount;
  logic [0:0]   extraDataOut;
  logic         idle, eccStatus, collisionError, counterError;

  int checks = 0;
  int errors = 0;

  streaming_core_dispatcher #(.NUM_CORES(4), .EXTRA_DATA_WIDTH(1), .CNT_WIDTH(10)) dut (
    .clk(clk), .rstn(rstn), .inValid(inValid), .graphIn(graphIn), .extraDataIn(extraDataIn),
    .inReady(inReady), .coreEnable(coreEnable), .coreSlowDown(coreSlowDown),
    .coreBotValid(coreBotValid), .coreGraph(coreGraph), .coreExtraData(coreExtraData),
    .coreResultValid(coreResultValid), .coreConnectCount(coreConnectCount),
    .coreExtraDataOut(coreExtraDataOut), .coreEcc(coreEcc), .resultValid(resultValid),
    .connectCount(connectCount), .extraDataOut(extraDataOut), .idle(idle),
    .eccStatus(eccStatus), .collisionError(collisionError), .counterError(counterError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] sd, rv, ecc, exin;
    logic [23:0] ccin;
    logic [7:0] g;
    logic       e_rdy;
    logic [3:0] e_bv;
    logic       e_rv;
    logic [5:0] e_cc;
    logic       e_ex;
    logic [7:0] e_g;
    logic [1:0] e_rr;
    logic       e_col, e_cerr, e_ecc;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [3:0] sd, input logic [3:0] rv,
                              input logic [23:0] ccin, input logic [3:0] exin, input logic [3:0] ecc,
                              input logic [7:0] g, input logic e_rdy, input logic [3:0] e_bv,
                              input logic e_rv, input logic [5:0] e_cc, input logic e_ex,
                              input logic [7:0] e_g, input logic [1:0] e_rr, input logic e_col,
                              input logic e_cerr, input logic e_ecc);
    vec_t v;
    v.iv = iv; v.sd = sd; v.rv = rv; v.ccin = ccin; v.exin = exin; v.ecc = ecc; v.g = g;
    v.e_rdy = e_rdy; v.e_bv = e_bv; v.e_rv = e_rv; v.e_cc = e_cc; v.e_ex = e_ex;
    v.e_g = e_g; v.e_rr = e_rr; v.e_col = e_col; v.e_cerr = e_cerr; v.e_ecc = e_ecc;
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, ".bv"}, 128'(coreBotValid), 128'h0);
    chk({tag, ".rv"}, 128'(resultValid), 128'h0);
    chk({tag, ".graph"}, coreGraph, 128'h0);
    chk({tag, ".cx"}, 128'(coreExtraData), 128'h0);
    chk({tag, ".cc"}, 128'(connectCount), 128'h0);
    chk({tag, ".ex"}, 128'(extraDataOut), 128'h0);
    chk({tag, ".flags"}, 128'({eccStatus, collisionError, counterError}), 128'h0);
    chk({tag, ".idle"}, 128'(idle), 128'h1);
    chk({tag, ".rr"}, 128'(dut.rr_ptr_q), 128'h0);
    chk({tag, ".cnt"}, 128'(dut.cnt), 128'h0);
  endtask

  initial begin
    // Round-robin over all cores, eight transfers back to back.
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1, 4'h0, 4'h0, 24'h0, 4'h0, 4'h0, 8'(i + 1),
                   1, 4'(1 << (i % 4)), 0, 6'd0, 0, 8'(i + 1), 2'((i + 1) % 4), 0, 0, 0);
    vecs[8]  = mk(0, 4'h0, 4'h0, 24'h0, 4'h0, 4'h0, 8'd0,  1, 4'b0000, 0, 6'd0, 0, 8'd8, 2'd0, 0, 0, 0);
    vecs[9]  = mk(1, 4'h0, 4'h0, 24'h0, 4'h0, 4'h0, 8'd9,  1, 4'b0001, 0, 6'd0, 0, 8'd9, 2'd1, 0, 0, 0);
    // rrPtr=1 with core 1 slowed: core 2 taken, pointer jumps to 3.
    vecs[10] = mk(1, 4'b0010, 4'h0, 24'h0, 4'h0, 4'h0, 8'd10, 1, 4'b0100, 0, 6'd0, 0, 8'd10, 2'd3, 0, 0, 0);
    vecs[11] = mk(1, 4'b1111, 4'h0, 24'h0, 4'h0, 4'h0, 8'd11, 0, 4'b0000, 0, 6'd0, 0, 8'd10, 2'd3, 0, 0, 0);
    vecs[12] = mk(0, 4'h0, 4'b0100, 24'(17) << 12, 4'b0100, 4'h0, 8'd0,
                  1, 4'b0000, 1, 6'd17, 1, 8'd10, 2'd3, 0, 0, 0);
    vecs[13] = mk(0, 4'h0, 4'b0110, (24'(33) << 12) | (24'(5) << 6), 4'b0100, 4'h0, 8'd0,
                  1, 4'b0000, 1, 6'd5, 0, 8'd10, 2'd3, 1, 0, 0);
    vecs[14] = mk(0, 4'h0, 4'h0, 24'h0, 4'h0, 4'h0, 8'd0, 1, 4'b0000, 0, 6'd5, 0, 8'd10, 2'd3, 1, 0, 0);
    vecs[15] = mk(0, 4'h0, 4'b0010, 24'(9) << 6, 4'h0, 4'h0, 8'd0,
                  1, 4'b0000, 1, 6'd9, 0, 8'd10, 2'd3, 1, 0, 0);
    // Core 1 is now at zero: another result underflows.
    vecs[16] = mk(0, 4'h0, 4'b0010, 24'(10) << 6, 4'h0, 4'h0, 8'd0,
                  1, 4'b0000, 1, 6'd10, 0, 8'd10, 2'd3, 1, 1, 0);
    vecs[17] = mk(0, 4'h0, 4'h0, 24'h0, 4'h0, 4'b1000, 8'd0, 1, 4'b0000, 0, 6'd10, 0, 8'd10, 2'd3, 1, 1, 1);
    vecs[18] = mk(0, 4'h0, 4'h0, 24'h0, 4'h0, 4'h0, 8'd0, 1, 4'b0000, 0, 6'd10, 0, 8'd10, 2'd3, 1, 1, 1);

    rstn = 1'b0; inValid = 1'b1; graphIn = '0; extraDataIn = '0;
    coreEnable = 4'hF; coreSlowDown = '0; coreResultValid = '0;
    coreConnectCount = '0; coreExtraDataOut = '0; coreEcc = '0;
    #12;
    check_reset_state("reset");
    inValid = 1'b0;
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      inValid          = vecs[i].iv;
      graphIn          = 128'(vecs[i].g);
      extraDataIn      = vecs[i].g[0];
      coreSlowDown     = vecs[i].sd;
      coreResultValid  = vecs[i].rv;
      coreConnectCount = vecs[i].ccin;
      coreExtraDataOut = vecs[i].exin;
      coreEcc          = vecs[i].ecc;
      #1;
      chk($sformatf("v%0d.inReady", i), 128'(inReady), 128'(vecs[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d.coreBotValid", i), 128'(coreBotValid), 128'(vecs[i].e_bv));
      chk($sformatf("v%0d.coreGraph", i), coreGraph, 128'(vecs[i].e_g));
      chk($sformatf("v%0d.coreExtraData", i), 128'(coreExtraData), 128'(vecs[i].e_g[0]));
      chk($sformatf("v%0d.resultValid", i), 128'(resultValid), 128'(vecs[i].e_rv));
      chk($sformatf("v%0d.connectCount", i), 128'(connectCount), 128'(vecs[i].e_cc));
      chk($sformatf("v%0d.extraDataOut", i), 128'(extraDataOut), 128'(vecs[i].e_ex));
      chk($sformatf("v%0d.rrPtr", i), 128'(dut.rr_ptr_q), 128'(vecs[i].e_rr));
      chk($sformatf("v%0d.collisionError", i), 128'(collisionError), 128'(vecs[i].e_col));
      chk($sformatf("v%0d.counterError", i), 128'(counterError), 128'(vecs[i].e_cerr));
      chk($sformatf("v%0d.eccStatus", i), 128'(eccStatus), 128'(vecs[i].e_ecc));
      if (i == 8) begin
        for (int c = 0; c < 4; c++)
          chk($sformatf("v8.cnt%0d", c), 128'(dut.cnt[c]), 128'd2);
        chk("v8.idle", 128'(idle), 128'h0);
      end
      if (i == 12) chk("v12.cnt2", 128'(dut.cnt[2]), 128'd2);
      if (i == 16) chk("v16.cnt1", 128'(dut.cnt[1]), 128'd0);
    end

    // Mid-operation reset with a dispatch strobe on the bus and counters nonzero.
    inValid = 1'b1; graphIn = 128'hAA; extraDataIn = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst.bv", 128'(coreBotValid), 128'b1000);
    chk("pre_rst.cnt0", 128'(dut.cnt[0]), 128'd3);
    #2 rstn = 1'b0;
    #1 check_reset_state("mid_reset");
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.bv", 128'(coreBotValid), 128'b0001);
    chk("post_rst.graph", coreGraph, 128'hAA);
    chk("post_rst.rr", 128'(dut.rr_ptr_q), 128'd1);
    inValid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.bv_clear", 128'(coreBotValid), 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
